// File: rtl/tt_response_checker_if.sv
// Bus between the truth-table response checker and its surroundings: DUT stimulus/response,
// golden ROM port, sweep control and results.
interface tt_response_checker_if #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 12
);
  localparam int unsigned ERR_W = $clog2(N_OUT * (2 ** N_IN) + 1);

  logic             start;
  logic [N_IN-1:0]  pi_out;
  logic [N_OUT-1:0] po_in;
  logic [N_IN-1:0]  exp_addr;
  logic [N_OUT-1:0] exp_data;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] fitness;
  logic             fail_valid;
  logic [N_IN-1:0]  first_fail_vec;

  modport master (
    input  start, po_in, exp_data,
    output pi_out, exp_addr, busy, done, err_count, fitness, fail_valid, first_fail_vec
  );

  modport slave (
    output start, po_in, exp_data,
    input  pi_out, exp_addr, busy, done, err_count, fitness, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/tt_response_checker.sv
// Sweeps all 2^N_IN input vectors through a combinational DUT and scores its responses
// against a golden truth table read from a synchronous ROM.
module tt_response_checker #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_response_checker_if.master bus
);
  localparam int unsigned NVEC  = 2 ** N_IN;
  localparam int unsigned TOTAL = N_OUT * NVEC;
  localparam int unsigned ERR_W = $clog2(TOTAL + 1);
  localparam int unsigned MW    = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [N_IN-1:0]  vec_q;
  logic [N_IN-1:0]  cmp_vec_q;
  logic [N_OUT-1:0] po_q;
  logic             cmp_valid_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] fitness_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_valid_q;
  logic [N_IN-1:0]  first_fail_q;

  logic [N_OUT-1:0] diff;
  logic [MW-1:0]    mism;
  logic [ERR_W-1:0] err_next;

  // ROM data lags exp_addr by one cycle, which lines it up with the registered response.
  assign diff = po_q ^ bus.exp_data;

  always_comb begin
    mism = '0;
    for (int i = 0; i < N_OUT; i++) begin
      mism = mism + MW'(diff[i]);
    end
  end

  assign err_next = cmp_valid_q ? err_q + ERR_W'(mism) : err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      cmp_vec_q    <= '0;
      po_q         <= '0;
      cmp_valid_q  <= 1'b0;
      err_q        <= '0;
      fitness_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (cmp_valid_q) begin
        err_q <= err_next;
        if (mism != '0 && !fail_valid_q) begin
          first_fail_q <= cmp_vec_q;
          fail_valid_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q      <= StRun;
            vec_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        StRun: begin
          po_q        <= bus.po_in;
          cmp_vec_q   <= vec_q;
          cmp_valid_q <= 1'b1;
          if (vec_q == N_IN'(NVEC - 1)) begin
            state_q <= StDrain;
          end else begin
            vec_q <= vec_q + 1'b1;
          end
        end
        StDrain: begin
          // Last compare retires this cycle, so fitness folds in err_next to be final with done.
          cmp_valid_q <= 1'b0;
          state_q     <= StDone;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          fitness_q   <= ERR_W'(TOTAL) - err_next;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pi_out         = vec_q;
  assign bus.exp_addr       = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_count      = err_q;
  assign bus.fitness        = fitness_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_vec = first_fail_q;
endmodule

// File: tb/tb_tt_response_checker.sv
// Directed and randomized sweeps of tt_response_checker against a golden ROM, a faultable DUT
// table and a whole-table reference score.
module tb_tt_response_checker;
  localparam int unsigned N_IN  = 6;
  localparam int unsigned N_OUT = 12;
  localparam int unsigned NVEC  = 64;
  localparam int unsigned TOTAL = 768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;

  logic [N_OUT-1:0] golden [NVEC];
  logic [N_OUT-1:0] rom    [NVEC];
  logic [N_OUT-1:0] dut_tab[NVEC];

  tt_response_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  tt_response_checker #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.exp_data <= rom[bus.exp_addr];
  assign bus.po_in = dut_tab[bus.pi_out];

  task automatic check(input string tag, input int obs, input int expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // mode 0 exact, 1 po00 stuck-0, 2 all inverted, 3 po06 stuck-1, 4 sparse random bit flips
  task automatic build_dut(input int mode);
    for (int v = 0; v < NVEC; v++) begin
      case (mode)
        0: dut_tab[v] = rom[v];
        1: dut_tab[v] = rom[v] & ~12'h001;
        2: dut_tab[v] = ~rom[v];
        3: dut_tab[v] = rom[v] | 12'h040;
        default: dut_tab[v] = ($urandom_range(0, 3) == 0) ? rom[v] ^ N_OUT'($urandom) : rom[v];
      endcase
    end
  endtask

  task automatic model(output int e, output int ff, output int fv);
    logic [N_OUT-1:0] d;
    e = 0; ff = 0; fv = 0;
    for (int v = 0; v < NVEC; v++) begin
      d = dut_tab[v] ^ rom[v];
      e += $countones(d);
      if (d != 0 && fv == 0) begin
        fv = 1;
        ff = v;
      end
    end
  endtask

  task automatic sweep(input string tag, input int ee, input int eff, input int efv,
                       input bit hold);
    int n;
    int ndone;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    check({tag, ".busy_run"}, bus.busy, 1);
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1;
    end
    check({tag, ".done_latency"}, n, 65);
    check({tag, ".err_count"}, bus.err_count, ee);
    check({tag, ".fitness"}, bus.fitness, TOTAL - ee);
    check({tag, ".fail_valid"}, bus.fail_valid, efv);
    check({tag, ".first_fail_vec"}, bus.first_fail_vec, eff);
    check({tag, ".busy_done"}, bus.busy, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, ".done_pulse_len"}, bus.done, 0);
    check({tag, ".pi_hold"}, bus.pi_out, NVEC - 1);
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check({tag, ".no_extra_done"}, ndone, 0);
    check({tag, ".err_held"}, bus.err_count, ee);
    check({tag, ".fitness_held"}, bus.fitness, TOTAL - ee);
  endtask

  initial begin
    int e, ff, fv, ndone;
    bus.start = 1'b0;
    for (int v = 0; v < NVEC; v++) begin
      golden[v]    = N_OUT'($urandom);
      golden[v][0] = ~v[0];
      golden[v][6] = (v == 0);
      rom[v]       = golden[v];
    end
    build_dut(0);

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.pi_out", bus.pi_out, 0);
    check("reset.exp_addr", bus.exp_addr, 0);
    check("reset.err_count", bus.err_count, 0);
    check("reset.fitness", bus.fitness, 0);
    check("reset.fail_valid", bus.fail_valid, 0);
    check("reset.first_fail_vec", bus.first_fail_vec, 0);
    rst = 1'b0;

    build_dut(0);
    sweep("golden", 0, 0, 0, 1'b0);
    build_dut(1);
    sweep("po00_sa0", 32, 0, 1, 1'b0);
    build_dut(2);
    sweep("invert_all", 768, 0, 1, 1'b0);
    build_dut(3);
    sweep("po06_sa1", 63, 1, 1, 1'b0);

    build_dut(1);
    sweep("hold_start", 32, 0, 1, 1'b1);
    sweep("rerun", 32, 0, 1, 1'b0);

    // Abort mid-sweep: the interval after the 20th edge past start is RUN cycle 20.
    build_dut(0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.busy", bus.busy, 0);
    check("abort.err_count", bus.err_count, 0);
    check("abort.pi_out", bus.pi_out, 0);
    check("abort.fail_valid", bus.fail_valid, 0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("abort.no_done", ndone, 0);
    sweep("after_abort", 0, 0, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      for (int v = 0; v < NVEC; v++) rom[v] = N_OUT'($urandom);
      build_dut(4);
      model(e, ff, fv);
      sweep($sformatf("random%0d", t), e, ff, fv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Sequential stimulus/response harness for the combinational truth-table benchmarks (6-input/12-output PLA circuits and evolved CGP candidates).
- Sweeps every input vector into a device-under-test (DUT) on its pi bus and captures the DUT's po response.
- Compares each response against a golden truth table held in an external synchronous ROM.
- Reports total mismatched output bits, the CGP fitness (correct bits) and the first failing vector.

Parameters:
- N_IN, 6, DUT input count; 2^N_IN vectors per sweep.
- N_OUT, 12, DUT output count and ROM data width.
- ERR_W, clog2(N_OUT*2^N_IN+1) = 10 at defaults, width of err_count and fitness. Localparam, derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin sweep; sampled in IDLE only.
- pi_out  out  N_IN  vector driven to DUT pi inputs (bit 0 = pi0).
- po_in  in  N_OUT  DUT outputs (bit 0 = po00). Combinational function of pi_out.
- exp_addr  out  N_IN  golden ROM address.
- exp_data  in  N_OUT  golden ROM data, valid 1 cycle after exp_addr.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when results are final.
- err_count  out  ERR_W  total mismatching bits.
- fitness  out  ERR_W  N_OUT*2^N_IN - err_count.
- fail_valid  out  1  at least one vector mismatched.
- first_fail_vec  out  N_IN  lowest vector index with any mismatch.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), from any state:
  - state=IDLE.
  - pi_out=0, exp_addr=0, busy=0, done=0.
  - err_count=0, fitness=0, fail_valid=0, first_fail_vec=0.
  - Pipeline valid bit cleared.
- States IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN. vec counter=0, err_count=0, fail_valid=0, first_fail_vec=0, busy=1 next cycle.
  - start=0 -> hold previous results.
- RUN (one vector per cycle):
  - pi_out = exp_addr = vec.
  - po_in is registered into po_q, vec into vec_q; cmp_valid<=1.
  - When vec = 2^N_IN-1 -> DRAIN; otherwise vec+1.
- Compare stage, each cycle with cmp_valid=1:
  - mism = popcount(po_q XOR exp_data); err_count += mism.
  - If mism!=0 and fail_valid=0: first_fail_vec<=vec_q, fail_valid<=1.
- DRAIN: one cycle; completes the last compare; cmp_valid<=0 -> DONE.
- DONE:
  - done=1 for exactly one cycle; fitness<=N_OUT*2^N_IN - err_count (registered).
  - busy=0 in DONE, then -> IDLE.
- Timing: start sampled at edge 0 -> RUN cycles 1..2^N_IN, DRAIN 2^N_IN+1, done high in cycle 2^N_IN+2 (66 at defaults).
- start while busy (RUN/DRAIN) or in DONE is ignored; no restart, no queuing.
- pi_out holds the last vector (2^N_IN-1) after a sweep until the next start or reset.
- err_count cannot overflow: its maximum is exactly N_OUT*2^N_IN. Counter is ERR_W bits, unsigned.
- fitness updates only in DONE. err_count and first_fail_vec are live during RUN but final only at done.
- Reset mid-sweep aborts with no done pulse; all results cleared.

Test Plan:
- ROM = golden m1 table, DUT = golden m1 netlist, start 1 cycle -> done at cycle 66, err_count=0, fitness=768, fail_valid=0.
- DUT po00 stuck-at-0 (golden po00 = ~pi0, true for 32 vectors) -> err_count=32, fitness=736, fail_valid=1, first_fail_vec=0.
- DUT with all 12 outputs inverted -> err_count=768, fitness=0, first_fail_vec=0.
- DUT po06 stuck-at-1 (golden true only at vector 0) -> err_count=63, first_fail_vec=1.
- start held high for the whole sweep plus pulse in the DONE cycle -> exactly one done pulse; second start after IDLE re-runs with identical results.
- rst asserted at RUN cycle 20 -> next cycle busy=0, err_count=0, pi_out=0, no done. New start -> full correct sweep with done at cycle 66.
